// File: rtl/shift_pkg.sv
// Shared types for the shift command queue.
//   shift_cmd_t : one queued barrel-shift command, packed into 8 bits
//                 {rotate, dir, amt[1:0], data[3:0]}
//   SHIFT_W     : operand width
//   DIR_RIGHT / DIR_LEFT : encodings of the dir field
package shift_pkg;

  localparam int SHIFT_W = 4;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef struct packed {
    logic               rotate;  // 1 = rotate, 0 = zero-fill
    logic               dir;     // DIR_RIGHT / DIR_LEFT
    logic [1:0]         amt;     // shift amount
    logic [SHIFT_W-1:0] data;    // operand
  } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_queue.sv
// Shift command queue: a small synchronous FIFO of barrel-shift commands
// sitting between a producer and a downstream barrel shifter.
//
// Ports
//   clk                     : clock, all state updates on rising edge
//   rst                     : synchronous active-high reset
//   in_valid / in_ready     : producer handshake (push on both high)
//   in_data/amt/dir/rotate  : command fields offered by the producer
//   out_valid / out_ready   : consumer handshake (pop on both high)
//   out_data/amt/dir/rotate : head command fields, straight from storage
//   count                   : number of occupied entries (0..DEPTH)
//   overflow                : sticky, set when a push is offered while full
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SHIFT_W-1:0]         in_data,
  input  logic [1:0]                 in_amt,
  input  logic                       in_dir,
  input  logic                       in_rotate,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SHIFT_W-1:0]         out_data,
  output logic [1:0]                 out_amt,
  output logic                       out_dir,
  output logic                       out_rotate,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  shift_cmd_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  shift_cmd_t     w_in_cmd;
  shift_cmd_t     w_head;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // in_ready looks only at occupancy, so a full queue never accepts a
  // command in the same cycle it frees a slot.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = out_ready && !w_empty;

  assign w_in_cmd = '{rotate: in_rotate, dir: in_dir, amt: in_amt, data: in_data};
  assign w_head   = r_mem[r_rd_ptr];

  assign out_data   = w_head.data;
  assign out_amt    = w_head.amt;
  assign out_dir    = w_head.dir;
  assign out_rotate = w_head.rotate;
  assign count      = r_count;
  assign overflow   = r_overflow;

  // Storage is not reset; entries beyond the pointers are never presented.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_in_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue with hand-computed expectations.
module tb_shift_cmd_queue;
  import shift_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_amt;
  logic       in_dir;
  logic       in_rotate;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_amt;
  logic       out_dir;
  logic       out_rotate;
  logic [2:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  shift_cmd_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .in_rotate  (in_rotate),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_amt    (out_amt),
    .out_dir    (out_dir),
    .out_rotate (out_rotate),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] d);
    in_valid = 1'b1; in_data = d; in_amt = d[1:0]; in_dir = d[0]; in_rotate = d[1];
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_expect(input logic [3:0] d, input string tag);
    chk({tag, "_v"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_d"}, {4'd0, out_data}, {4'd0, d});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amt = '0; in_dir = 1'b0; in_rotate = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset then idle
    chk("rst_count",  {5'd0, count}, 8'd0);
    chk("rst_ovalid", {7'd0, out_valid}, 8'd0);
    chk("rst_iready", {7'd0, in_ready}, 8'd1);
    chk("rst_ovf",    {7'd0, overflow}, 8'd0);

    // Single push, full field check, then hold stable with out_ready=0
    in_valid = 1'b1; in_data = 4'hA; in_amt = 2'd1; in_dir = DIR_LEFT; in_rotate = 1'b0;
    step();
    in_valid = 1'b0; in_data = 4'h5; in_amt = 2'd2; in_dir = DIR_RIGHT; in_rotate = 1'b1;
    chk("p1_ovalid", {7'd0, out_valid}, 8'd1);
    chk("p1_data",   {4'd0, out_data}, 8'hA);
    chk("p1_amt",    {6'd0, out_amt}, 8'd1);
    chk("p1_dir",    {7'd0, out_dir}, 8'd1);
    chk("p1_rot",    {7'd0, out_rotate}, 8'd0);
    chk("p1_count",  {5'd0, count}, 8'd1);
    step();
    chk("hold_data", {4'd0, out_data}, 8'hA);
    chk("hold_amt",  {6'd0, out_amt}, 8'd1);

    // Fill, overflow attempt, drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    chk("full_count",  {5'd0, count}, 8'd4);
    chk("full_iready", {7'd0, in_ready}, 8'd0);
    in_valid = 1'b1; in_data = 4'h5;
    step();
    in_valid = 1'b0;
    chk("ovf_flag",  {7'd0, overflow}, 8'd1);
    chk("ovf_count", {5'd0, count}, 8'd4);
    for (int i = 1; i <= 4; i++) drain_expect(4'(i), "drain");
    chk("drain_empty", {7'd0, out_valid}, 8'd0);
    chk("drain_count", {5'd0, count}, 8'd0);
    chk("ovf_sticky",  {7'd0, overflow}, 8'd1);

    // Steady state push+pop at count=2 across pointer wrap
    do_reset();
    push(4'd1);
    push(4'd2);
    for (int k = 0; k < 6; k++) begin
      chk("ss_head", {4'd0, out_data}, 8'(1 + k));
      in_valid = 1'b1; in_data = 4'(3 + k); in_amt = 2'(k); in_dir = 1'b0; in_rotate = 1'b0;
      out_ready = 1'b1;
      step();
      chk("ss_count", {5'd0, count}, 8'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    drain_expect(4'd7, "ss_tail");
    drain_expect(4'd8, "ss_tail");

    // Full with pop and push both offered: pop only, then both
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b1;
    chk("fp_iready0", {7'd0, in_ready}, 8'd0);
    step();
    chk("fp_count1",  {5'd0, count}, 8'd3);
    chk("fp_iready1", {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fp_count2",  {5'd0, count}, 8'd3);
    drain_expect(4'd3, "fp_drain");
    drain_expect(4'd4, "fp_drain");
    drain_expect(4'd9, "fp_drain");

    // Reset mid-operation with count=3 and overflow set
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    in_valid = 1'b1; in_data = 4'hE;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mr_pre_cnt", {5'd0, count}, 8'd3);
    chk("mr_pre_ovf", {7'd0, overflow}, 8'd1);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mr_count",  {5'd0, count}, 8'd0);
    chk("mr_ovalid", {7'd0, out_valid}, 8'd0);
    chk("mr_ovf",    {7'd0, overflow}, 8'd0);
    push(4'h6);
    chk("mr_first",  {4'd0, out_data}, 8'h6);
    chk("mr_cnt1",   {5'd0, count}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
